bcd_countdown_timer: RTL
========================

// Module: bcd_countdown_timer
// PURPOSE
//   Multi-digit BCD down-counter with borrow chain: the decrementing counterpart of the
//   decade up-counter digit. Loads a BCD preset, counts down one unit per tick while
//   running, and flags expiry at 0. Used as the countdown/timer stage in the demo designs.
//   Never wraps below zero.
// PARAMETERS
//   DIGITS   4   number of BCD digits; value width = 4*DIGITS
// PORTS
//   clk       in   1          system clock, all state on rising edge
//   reset     in   1          synchronous, active-high reset
//   load      in   1          load load_val into counter, return to IDLE
//   load_val  in   4*DIGITS   BCD preset, digit 0 in [3:0]
//   start     in   1          start/resume counting
//   pause     in   1          suspend counting
//   tick      in   1          count enable; one decrement per high cycle while RUN
//   q         out  4*DIGITS   current BCD value, registered
//   running   out  1          1 iff state==RUN
//   expired   out  1          1 iff state==DONE
//   done      out  1          single-cycle pulse on the edge where q reaches 0
// BEHAVIOUR
//   - Reset (sync, priority over everything): q=0, state=IDLE, running=0, expired=0, done=0.
//   - FSM states: IDLE, RUN, PAUSED, DONE. All outputs registered/derived from registers.
//   - Priority per edge: reset > load > pause > start > tick.
//   - load (any state): q <= sanitised load_val, state=IDLE, done=0. Sanitise: any digit >9
//     becomes 9; other digits are copied unchanged.
//   - IDLE: start with q!=0 -> RUN. start with q==0 is ignored (stays IDLE). tick ignored.
//   - RUN: pause -> PAUSED (no decrement that edge). Otherwise tick=1 decrements q by 1:
//     digit i decrements iff all digits below i are 0; a digit at 0 that decrements
//     becomes 9 (borrow). Digit 0 always decrements on a valid tick.
//   - RUN, tick=1, q==1: q <= 0, state <= DONE, done <= 1 on the same edge (zero latency
//     between q reaching 0 and done/expired).
//   - PAUSED: start (pause=0) -> RUN. tick ignored, q held.
//   - DONE: q held at 0, expired=1. tick/start/pause ignored. Exit only via load or reset.
//   - done is high exactly one cycle; cleared on the next edge regardless of inputs.
//   - start and pause never change q. Latency tick->q: 1 edge.
// TESTING
//   1. reset; load 16'h0102; start; tick x3 -> q 0102,0101,0100,0099; running=1.
//   2. load 16'h0001; start; tick -> q=0000, done=1 for 1 cycle, expired=1; more ticks keep 0000.
//   3. load 16'h0050; start; tick; pause; tick x4 -> q=0049 held; start; tick -> 0048.
//   4. load 16'h00AF -> q=0099; load 16'hF000 -> q=9000.
//   5. load 16'h1000; start; tick -> q=0999; reset with tick=1 -> q=0, running=0, expired=0.
//   6. start with q=0 -> stays IDLE; load 16'h0005 with start=1 same edge -> q=0005, IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with borrow chain, start/pause control and expiry flag.
// Counts down one unit per tick while running and stops at zero; never wraps.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] q,
  output logic                running,
  output logic                expired,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   q_sanitised;
  logic [W-1:0]   q_decremented;
  logic           q_is_one;
  logic           q_is_zero;

  // Out-of-range preset digits clamp to 9 so the counter never holds a non-BCD digit.
  always_comb begin
    q_sanitised = '0;
    for (int i = 0; i < DIGITS; i++) begin
      q_sanitised[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Ripple borrow: a digit steps down only when every lower digit is 0, and 0 wraps to 9.
  always_comb begin
    logic borrow;
    borrow        = 1'b1;
    q_decremented = q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        q_decremented[4*i +: 4] = (q[4*i +: 4] == 4'd0) ? 4'd9 : q[4*i +: 4] - 4'd1;
      end
      borrow = borrow && (q[4*i +: 4] == 4'd0);
    end
  end

  assign q_is_one  = (q == W'(1));
  assign q_is_zero = (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q     <= q_sanitised;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!pause && start && !q_is_zero) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (pause) begin
              state <= PAUSED;
            end else if (tick) begin
              q <= q_decremented;
              // Reaching zero and flagging expiry happen on the same edge.
              if (q_is_one) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (!pause && start) begin
              state <= RUN;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign running = (state == RUN);
  assign expired = (state == DONE);

endmodule
